// File: rtl/vtpg_multi.sv
// Video timing and test-pattern generator.
// Free-running raster counter (x, y) with programmable sync/active windows and
// four selectable patterns. Every output is registered one cycle behind the
// counter position. Pattern selection is sampled only at frame start so a
// frame is never rendered with mixed settings.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | counters parked, all outputs low, frame_cnt held, waiting for en
// S_RUN  | raster scanning; a frame always runs to completion once started

module vtpg_multi #(
    parameter int H_BITS    = 12,
    parameter int V_BITS    = 12,
    parameter int PW        = 8,
    parameter int FC_BITS   = 16,
    parameter int BAR_SHIFT = 4,
    parameter int CHK_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [3*PW-1:0]      solid_rgb,
    input  logic [H_BITS-1:0]    tH_END,
    input  logic [H_BITS-1:0]    tHS_START,
    input  logic [H_BITS-1:0]    tHS_END,
    input  logic [H_BITS-1:0]    tHACT_START,
    input  logic [H_BITS-1:0]    tHACT_END,
    input  logic [V_BITS-1:0]    tV_END,
    input  logic [V_BITS-1:0]    tVS_START,
    input  logic [V_BITS-1:0]    tVS_END,
    input  logic [V_BITS-1:0]    tVACT_START,
    input  logic [V_BITS-1:0]    tVACT_END,
    output logic                 hs,
    output logic                 vs,
    output logic                 vld,
    output logic [3*PW-1:0]      rgb,
    output logic                 sof,
    output logic [FC_BITS-1:0]   frame_cnt,
    output logic                 busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [H_BITS-1:0]   r_x, w_x_nxt;
    logic [V_BITS-1:0]   r_y, w_y_nxt;
    logic [FC_BITS-1:0]  r_fc, w_fc_nxt;
    logic [PW-1:0]       r_ramp, w_ramp_nxt;
    logic [1:0]          r_mode;
    logic [3*PW-1:0]     r_solid;
    logic                w_frame_start;
    logic                w_line_end;
    logic                w_frame_end;

    logic                r_hs, r_vs, r_vld, r_sof, r_busy;
    logic [3*PW-1:0]     r_rgb;

    logic                w_hs, w_vs, w_vld;
    logic [H_BITS-1:0]   w_ax;
    logic [2:0]          w_bar;
    logic                w_chk_x, w_chk_y;
    logic [PW-1:0]       w_full;
    logic [3*PW-1:0]     w_pix;

    // Wrap uses >= so a timing change mid-frame that lands below the current
    // position still wraps at the new end instead of running to 2^N.
    assign w_line_end  = (r_x >= tH_END);
    assign w_frame_end = w_line_end && (r_y >= tV_END);

    // State, raster counters and frame-start settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_fc    <= '0;
            r_ramp  <= '0;
            r_mode  <= '0;
            r_solid <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_fc    <= w_fc_nxt;
            r_ramp  <= w_ramp_nxt;
            if (w_frame_start) begin
                r_mode  <= mode;
                r_solid <= solid_rgb;
            end
        end
    end

    // Next-state and counter advance; en is only looked at on frame boundaries.
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_fc_nxt      = r_fc;
        w_frame_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt   = S_RUN;
                    w_x_nxt       = '0;
                    w_y_nxt       = '0;
                    w_frame_start = 1'b1;
                end
            end
            S_RUN: begin
                if (w_line_end) begin
                    w_x_nxt = '0;
                    if (w_frame_end) begin
                        w_y_nxt  = '0;
                        w_fc_nxt = r_fc + 1'b1;
                        if (en) begin
                            w_frame_start = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_y_nxt = r_y + 1'b1;
                    end
                end else begin
                    w_x_nxt = r_x + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window decode for the current counter position.
    always_comb begin
        w_hs  = (r_x >= tHS_START) && (r_x < tHS_END);
        w_vs  = (r_y >= tVS_START) && (r_y < tVS_END);
        w_vld = (r_x >= tHACT_START) && (r_x < tHACT_END) &&
                (r_y >= tVACT_START) && (r_y < tVACT_END);
    end

    // Ramp advances after each active pixel and restarts with every frame.
    always_comb begin
        w_ramp_nxt = r_ramp;
        if (w_frame_start) begin
            w_ramp_nxt = '0;
        end else if ((r_state == S_RUN) && w_vld) begin
            w_ramp_nxt = r_ramp + 1'b1;
        end
    end

    // Pattern generation; coordinates are relative to the active-window origin.
    always_comb begin
        w_ax    = r_x - tHACT_START;
        w_bar   = 3'(w_ax >> BAR_SHIFT);
        w_chk_x = 1'(w_ax >> CHK_SHIFT);
        w_chk_y = 1'((r_y - tVACT_START) >> CHK_SHIFT);
        w_full  = {PW{1'b1}};
        w_pix   = '0;
        case (r_mode)
            2'd0: w_pix = {r_ramp, r_ramp, r_ramp};
            2'd1: w_pix = {(w_bar[1] ? {PW{1'b0}} : w_full),
                           (w_bar[2] ? {PW{1'b0}} : w_full),
                           (w_bar[0] ? {PW{1'b0}} : w_full)};
            2'd2: w_pix = (w_chk_x ^ w_chk_y) ? {3*PW{1'b0}} : {3*PW{1'b1}};
            default: w_pix = r_solid;
        endcase
    end

    // Output register: one-cycle latency behind (x, y), forced low in idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_vld  <= 1'b0;
            r_rgb  <= '0;
            r_sof  <= 1'b0;
            r_busy <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_hs   <= w_hs;
            r_vs   <= w_vs;
            r_vld  <= w_vld;
            r_rgb  <= w_vld ? w_pix : '0;
            r_sof  <= (r_x == '0) && (r_y == '0);
            r_busy <= 1'b1;
        end else begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_vld  <= 1'b0;
            r_rgb  <= '0;
            r_sof  <= 1'b0;
            r_busy <= 1'b0;
        end
    end

    assign hs        = r_hs;
    assign vs        = r_vs;
    assign vld       = r_vld;
    assign rgb       = r_rgb;
    assign sof       = r_sof;
    assign busy      = r_busy;
    assign frame_cnt = r_fc;

endmodule

// File: tb/tb_vtpg_multi.sv
// Directed bench for vtpg_multi: 10x5 raster (50 cycles/frame), small bar and
// checker sizes, 2-bit frame counter so wrap is reached quickly.

module tb_vtpg_multi;

    localparam int PW  = 8;
    localparam int HB  = 12;
    localparam int VB  = 12;
    localparam int FCB = 2;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [1:0]      mode;
    logic [3*PW-1:0] solid_rgb;
    logic [HB-1:0]   tH_END, tHS_START, tHS_END, tHACT_START, tHACT_END;
    logic [VB-1:0]   tV_END, tVS_START, tVS_END, tVACT_START, tVACT_END;
    logic            hs, vs, vld, sof, busy;
    logic [3*PW-1:0] rgb;
    logic [FCB-1:0]  frame_cnt;

    int              checks = 0;
    int              errors = 0;
    logic [FCB-1:0]  exp_fc;

    vtpg_multi #(
        .H_BITS(HB), .V_BITS(VB), .PW(PW), .FC_BITS(FCB),
        .BAR_SHIFT(1), .CHK_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .tH_END(tH_END), .tHS_START(tHS_START), .tHS_END(tHS_END),
        .tHACT_START(tHACT_START), .tHACT_END(tHACT_END),
        .tV_END(tV_END), .tVS_START(tVS_START), .tVS_END(tVS_END),
        .tVACT_START(tVACT_START), .tVACT_END(tVACT_END),
        .hs(hs), .vs(vs), .vld(vld), .rgb(rgb), .sof(sof),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_hs"},   64'(hs),   64'd0);
        chk({tag, "_vs"},   64'(vs),   64'd0);
        chk({tag, "_vld"},  64'(vld),  64'd0);
        chk({tag, "_rgb"},  64'(rgb),  64'd0);
        chk({tag, "_sof"},  64'(sof),  64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One full frame of pixel checks. At x=3,y=2 the next mode/solid/en are
    // applied; they must not affect this frame.
    task automatic run_frame(input logic [1:0] m, input logic [23:0] sol,
                             input logic [1:0] nm, input logic [23:0] ns, input logic ne);
        int         x, y, ax, ay;
        logic [7:0] ramp;
        logic [23:0] e_rgb;
        logic       e_hs, e_vs, e_vld;
        ramp = 8'd0;
        for (int c = 0; c < 50; c++) begin
            tick;
            x = c % 10;
            y = c / 10;
            e_hs  = (x >= 1) && (x < 3);
            e_vs  = (y == 0);
            e_vld = (x >= 4) && (x < 8) && (y >= 1) && (y < 3);
            ax = x - 4;
            ay = y - 1;
            case (m)
                2'd0: e_rgb = {ramp, ramp, ramp};
                2'd1: e_rgb = (ax < 2) ? 24'hFFFFFF : 24'hFFFF00;
                2'd2: e_rgb = ((((ax >> 1) ^ (ay >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
                default: e_rgb = sol;
            endcase
            if (!e_vld) e_rgb = 24'h0;
            chk($sformatf("hs_m%0d_c%0d", m, c),   64'(hs),   64'(e_hs));
            chk($sformatf("vs_m%0d_c%0d", m, c),   64'(vs),   64'(e_vs));
            chk($sformatf("vld_m%0d_c%0d", m, c),  64'(vld),  64'(e_vld));
            chk($sformatf("rgb_m%0d_c%0d", m, c),  64'(rgb),  64'(e_rgb));
            chk($sformatf("sof_m%0d_c%0d", m, c),  64'(sof),  64'(c == 0));
            chk($sformatf("busy_m%0d_c%0d", m, c), 64'(busy), 64'd1);
            if (c == 49) exp_fc = exp_fc + 1'b1;
            chk($sformatf("fc_m%0d_c%0d", m, c),   64'(frame_cnt), 64'(exp_fc));
            if (e_vld) ramp = ramp + 8'd1;
            if (c == 22) begin
                mode      = nm;
                solid_rgb = ns;
                en        = ne;
            end
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        en          = 1'b0;
        mode        = 2'd0;
        solid_rgb   = '0;
        tH_END      = 12'd9;
        tHS_START   = 12'd1;
        tHS_END     = 12'd3;
        tHACT_START = 12'd4;
        tHACT_END   = 12'd8;
        tV_END      = 12'd4;
        tVS_START   = 12'd0;
        tVS_END     = 12'd1;
        tVACT_START = 12'd1;
        tVACT_END   = 12'd3;
        exp_fc      = '0;

        #12;
        check_idle("reset");
        chk("reset_fc", 64'(frame_cnt), 64'd0);

        tick;
        rst_n = 1'b1;
        tick;
        check_idle("idle_en0");

        en = 1'b1;
        tick;
        chk("entry_sof",  64'(sof),  64'd0);
        chk("entry_busy", 64'(busy), 64'd0);

        run_frame(2'd0, 24'h0,      2'd0, 24'h0,      1'b1);
        run_frame(2'd0, 24'h0,      2'd3, 24'h123456, 1'b1);
        run_frame(2'd3, 24'h123456, 2'd1, 24'h0,      1'b1);
        run_frame(2'd1, 24'h0,      2'd2, 24'h0,      1'b1);
        run_frame(2'd2, 24'h0,      2'd0, 24'h0,      1'b0);

        tick;
        check_idle("after_drop");
        chk("after_drop_fc", 64'(frame_cnt), 64'(exp_fc));
        tick;
        tick;
        check_idle("idle_hold");
        chk("idle_hold_fc", 64'(frame_cnt), 64'(exp_fc));

        en = 1'b1;
        tick;
        for (int i = 0; i < 13; i++) tick;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        chk("async_rst_fc", 64'(frame_cnt), 64'd0);
        exp_fc = '0;
        tick;
        tick;
        check_idle("rst_held");
        rst_n = 1'b1;
        tick;
        chk("reentry_sof",  64'(sof),  64'd0);
        chk("reentry_busy", 64'(busy), 64'd0);
        run_frame(2'd0, 24'h0, 2'd0, 24'h0, 1'b0);
        tick;
        check_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
